// File: rtl/lru_pkg.sv
// Shared types and default sizing for the LRU tick tracker.
// Build with LRU_TICK_PERF_EN defined to add the access/renormalisation counters.
package lru_pkg;

  localparam int LRU_NUM_WAYS   = 32;
  localparam int LRU_KEY_WIDTH  = 6;
  localparam int LRU_TICK_WIDTH = 32;

  typedef logic [LRU_TICK_WIDTH-1:0] tick_t;
  typedef logic [LRU_KEY_WIDTH-1:0]  way_idx_t;

  typedef enum logic {
    RUN    = 1'b0,
    RENORM = 1'b1
  } lru_state_e;

  localparam tick_t TICK_MAX = '1;

endpackage

// File: rtl/lru_tick_tracker_if.sv
// Access request channel into the tracker and the tick array it publishes
// to the victim selector.
interface lru_tick_tracker_if
  import lru_pkg::*;
#(
  parameter int NUM_WAYS   = LRU_NUM_WAYS,
  parameter int KEY_WIDTH  = LRU_KEY_WIDTH,
  parameter int TICK_WIDTH = LRU_TICK_WIDTH
);
  logic                                 acc_valid;
  logic                                 acc_ready;
  logic [KEY_WIDTH-1:0]                 acc_way;
  logic                                 acc_inv;
  logic [1:NUM_WAYS][TICK_WIDTH-1:0]    tick;
  logic                                 busy;

  modport master (
    output acc_valid, acc_way, acc_inv,
    input  acc_ready, tick, busy
  );

  modport slave (
    input  acc_valid, acc_way, acc_inv,
    output acc_ready, tick, busy
  );
endinterface

// File: rtl/lru_renorm_seq.sv
// Walks the way index 1..NUM_WAYS during a halving pass and flags the last way.
module lru_renorm_seq
  import lru_pkg::*;
#(
  parameter int NUM_WAYS  = LRU_NUM_WAYS,
  parameter int KEY_WIDTH = LRU_KEY_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 active,
  output logic [KEY_WIDTH-1:0] idx,
  output logic                 done
);

  always_ff @(posedge clk) begin
    if (reset || start) begin
      idx <= KEY_WIDTH'(1);
    end else if (active && !done) begin
      idx <= idx + 1'b1;
    end
  end

  assign done = active && (idx == KEY_WIDTH'(NUM_WAYS));

endmodule

// File: rtl/lru_tick_tracker.sv
// Per-way LRU timestamp writer: stamps used ways, zeroes invalidated ways and
// halves every tick when the global counter saturates. Optional: LRU_TICK_PERF_EN.
module lru_tick_tracker
  import lru_pkg::*;
#(
  parameter int NUM_WAYS   = LRU_NUM_WAYS,
  parameter int KEY_WIDTH  = LRU_KEY_WIDTH,
  parameter int TICK_WIDTH = LRU_TICK_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  lru_tick_tracker_if.slave    bus
`ifdef LRU_TICK_PERF_EN
  ,
  output logic [31:0]          perf_acc_cnt,
  output logic [31:0]          perf_renorm_cnt
`endif
);

  localparam logic [TICK_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [TICK_WIDTH-1:0] CNT_HALF = {1'b1, {(TICK_WIDTH-1){1'b0}}};

  lru_state_e                        state, state_nxt;
  logic [TICK_WIDTH-1:0]             cnt;
  logic [1:NUM_WAYS][TICK_WIDTH-1:0] tick_q;
  logic                              accept, legal, use_acc, start;
  logic                              renorm_active, renorm_done;
  logic [KEY_WIDTH-1:0]              renorm_idx;

  assign accept  = bus.acc_valid & bus.acc_ready;
  assign legal   = (bus.acc_way != '0) && (bus.acc_way <= KEY_WIDTH'(NUM_WAYS));
  assign use_acc = accept & legal & ~bus.acc_inv;
  assign start   = use_acc & (cnt == CNT_MAX);
  assign renorm_active = (state == RENORM);

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (start)       state_nxt = RENORM;
      RENORM:  if (renorm_done) state_nxt = RUN;
      default:                  state_nxt = RUN;
    endcase
  end

  always_comb begin
    bus.acc_ready = (state == RUN);
    bus.busy      = (state == RENORM);
  end

  lru_renorm_seq #(
    .NUM_WAYS  (NUM_WAYS),
    .KEY_WIDTH (KEY_WIDTH)
  ) u_renorm_seq (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .active (renorm_active),
    .idx    (renorm_idx),
    .done   (renorm_done)
  );

  // The way that triggers overflow is stamped with CNT_MAX first, then halved
  // with the rest during the pass.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q <= '0;
    end else if (renorm_active) begin
      for (int w = 1; w <= NUM_WAYS; w++) begin
        if (renorm_idx == KEY_WIDTH'(w)) tick_q[w] <= tick_q[w] >> 1;
      end
    end else if (accept && legal) begin
      for (int w = 1; w <= NUM_WAYS; w++) begin
        if (bus.acc_way == KEY_WIDTH'(w)) tick_q[w] <= bus.acc_inv ? '0 : cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= TICK_WIDTH'(1);
    end else if (renorm_done) begin
      cnt <= CNT_HALF;
    end else if (use_acc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.tick = tick_q;

`ifdef LRU_TICK_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_acc_cnt    <= '0;
      perf_renorm_cnt <= '0;
    end else begin
      if (accept && legal) perf_acc_cnt    <= perf_acc_cnt + 1'b1;
      if (start)           perf_renorm_cnt <= perf_renorm_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_lru_tick_tracker.sv
// Directed and random checks of lru_tick_tracker against a tick-array model.
module tb_lru_tick_tracker;

  localparam int NW = 4;
  localparam int KW = 3;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lru_tick_tracker_if #(.NUM_WAYS(NW), .KEY_WIDTH(KW), .TICK_WIDTH(TW)) bus ();

`ifdef LRU_TICK_PERF_EN
  logic [31:0] perf_acc_cnt, perf_renorm_cnt;
`endif

  lru_tick_tracker #(.NUM_WAYS(NW), .KEY_WIDTH(KW), .TICK_WIDTH(TW)) dut (
    .clk             (clk),
    .reset           (reset),
    .bus             (bus)
`ifdef LRU_TICK_PERF_EN
    ,
    .perf_acc_cnt    (perf_acc_cnt),
    .perf_renorm_cnt (perf_renorm_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference: the halved array is computed in one go when overflow happens;
  // the DUT is only compared against it once the busy window has elapsed.
  int mtick [1:NW];
  int mcnt;
  int busy_left;
  int macc, mren;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 1; i <= NW; i++) mtick[i] = 0;
    mcnt = 1;
    busy_left = 0;
    macc = 0;
    mren = 0;
  endtask

  task automatic check_outputs();
    chk("acc_ready", 32'(bus.acc_ready), 32'(busy_left == 0));
    chk("busy", 32'(bus.busy), 32'(busy_left != 0));
    if (busy_left == 0) begin
      for (int i = 1; i <= NW; i++)
        chk($sformatf("tick[%0d]", i), 32'(bus.tick[i]), 32'(mtick[i]));
    end
`ifdef LRU_TICK_PERF_EN
    chk("perf_acc_cnt", perf_acc_cnt, 32'(macc));
    chk("perf_renorm_cnt", perf_renorm_cnt, 32'(mren));
`endif
  endtask

  task automatic step(input bit rst, input bit v, input int w, input bit inv);
    reset         = rst;
    bus.acc_valid = v;
    bus.acc_way   = KW'(w);
    bus.acc_inv   = inv;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) mcnt = 1 << (TW - 1);
    end else if (v && w >= 1 && w <= NW) begin
      macc++;
      if (inv) begin
        mtick[w] = 0;
      end else begin
        mtick[w] = mcnt;
        if (mcnt == (1 << TW) - 1) begin
          for (int i = 1; i <= NW; i++) mtick[i] = mtick[i] / 2;
          busy_left = NW;
          mren++;
        end else begin
          mcnt++;
        end
      end
    end
    #1;
    check_outputs();
  endtask

  initial begin
    reset = 1'b1;
    bus.acc_valid = 1'b0;
    bus.acc_way = '0;
    bus.acc_inv = 1'b0;
    model_reset();

    step(1, 0, 0, 0);
    chk("reset_ready", 32'(bus.acc_ready), 32'd1);

    // Basic stamping and invalidate
    step(0, 1, 3, 0);
    chk("use3_tick3", 32'(bus.tick[3]), 32'd1);
    step(0, 1, 1, 0);
    chk("use1_tick1", 32'(bus.tick[1]), 32'd2);
    step(0, 1, 3, 1);
    chk("inv3_tick3", 32'(bus.tick[3]), 32'd0);
    step(0, 1, 2, 0);
    chk("use2_tick2", 32'(bus.tick[2]), 32'd3);

    // Illegal ways are consumed without effect
    step(0, 1, 0, 0);
    step(0, 1, 5, 0);
    step(0, 1, 4, 0);
    chk("after_illegal_tick4", 32'(bus.tick[4]), 32'd4);

    // Walk cnt up to the overflow point with ticks {13,14,12,x}
    for (int k = 0; k < 7; k++) step(0, 1, 4, 0);
    step(0, 1, 3, 0);
    step(0, 1, 1, 0);
    step(0, 1, 2, 0);
    step(0, 1, 4, 0);
    chk("renorm_busy", 32'(bus.busy), 32'd1);
    // acc_valid held across the pass
    for (int k = 0; k < NW; k++) step(0, 1, 2, 0);
    chk("halved_tick1", 32'(bus.tick[1]), 32'd6);
    chk("halved_tick2", 32'(bus.tick[2]), 32'd7);
    chk("halved_tick3", 32'(bus.tick[3]), 32'd6);
    chk("halved_tick4", 32'(bus.tick[4]), 32'd7);
    step(0, 1, 2, 0);
    chk("held_tick2", 32'(bus.tick[2]), 32'd8);
    step(0, 1, 1, 0);
    chk("post_tick1", 32'(bus.tick[1]), 32'd9);

    // Overflow again, then reset on the second cycle of the pass
    for (int k = 0; k < 6; k++) step(0, 1, 3, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("abort_ready", 32'(bus.acc_ready), 32'd1);
    for (int i = 1; i <= NW; i++)
      chk($sformatf("abort_tick[%0d]", i), 32'(bus.tick[i]), 32'd0);
`ifdef LRU_TICK_PERF_EN
    chk("abort_perf_acc", perf_acc_cnt, 32'd0);
    chk("abort_perf_renorm", perf_renorm_cnt, 32'd0);
`endif
    step(0, 1, 2, 0);
    chk("abort_cnt_restart", 32'(bus.tick[2]), 32'd1);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      step(($urandom % 64) == 0, ($urandom % 4) != 0,
           int'($urandom_range(0, 7)), ($urandom % 5) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
